// File: rtl/pack_wren_scheduler.sv
// pack_wren_scheduler: steers the USB3 cache word stream into the 24 sample RAM banks.
// It finds packet headers, decodes the packet type and writes each payload word to its bank.
// Ports:
//   rdclock    block clock, same domain as the cache read port
//   rst        asynchronous reset, active-high
//   in_data    cache word
//   in_valid   in_data valid; a word is accepted when in_valid && in_ready
//   in_ready   block can accept a word (low only in DONE)
//   wren       one-hot bank write enable, one cycle after the payload word is accepted
//   wr_addr    word address within the selected bank
//   wr_data    registered payload word
//   busy       state is not IDLE
//   pack_done  one-cycle pulse after the last word of a packet
//   soft_rst   one-cycle pulse on the soft-reset command
//   err_count  saturating protocol error count
module pack_wren_scheduler #(
  parameter int CA_LEN = 32,
  parameter int B_LEN  = 10,
  parameter int C_LEN  = 64
) (
  input  logic        rdclock,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] wren,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        pack_done,
  output logic        soft_rst,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    STREAM,
    DONE
  } state_t;

  localparam logic [7:0] CA_LAST = 8'(CA_LEN - 1);
  localparam logic [7:0] B_LAST  = 8'(B_LEN - 1);
  localparam logic [7:0] C_LAST  = 8'(C_LEN - 1);

  state_t      st, st_n;
  logic [4:0]  bank, bank_n;
  logic [4:0]  last_bank, last_bank_n;
  logic [7:0]  last_idx, last_idx_n;
  logic [7:0]  cnt, cnt_n;
  logic [23:0] wren_n;
  logic [7:0]  addr_n;
  logic [31:0] data_n;
  logic        done_n;
  logic        soft_n;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;
  logic [7:0]  err_n;
  logic        acc;
  logic        hdr;
  logic [15:0] typ;

  assign in_ready = (st != DONE);
  assign busy     = (st != IDLE);
  assign acc      = in_valid && in_ready;
  assign hdr      = (in_data & 32'hFF0000FF) == 32'hFF0000AA;
  assign typ      = in_data[23:8];

  always_comb begin
    st_n        = st;
    bank_n      = bank;
    last_bank_n = last_bank;
    last_idx_n  = last_idx;
    cnt_n       = cnt;
    wren_n      = '0;
    addr_n      = wr_addr;
    data_n      = wr_data;
    done_n      = 1'b0;
    soft_n      = 1'b0;
    err_inc     = 2'd0;
    if (st == DONE) begin
      st_n = IDLE;
    end else if (acc && hdr) begin
      // A header inside a packet aborts it, then decodes as a fresh header.
      if (st != IDLE) err_inc = 2'd1;
      cnt_n = '0;
      st_n  = IDLE;
      unique case (1'b1)
        typ == 16'h0000: begin
          st_n        = STREAM;
          bank_n      = 5'd0;
          last_bank_n = 5'd7;
          last_idx_n  = CA_LAST;
        end
        typ == 16'h000A: begin
          st_n        = STREAM;
          bank_n      = 5'd8;
          last_bank_n = 5'd15;
          last_idx_n  = B_LAST;
        end
        typ == 16'h00AA: st_n = SEL;
        typ == 16'h0A0A: soft_n = 1'b1;
        default: err_inc = err_inc + 2'd1;
      endcase
    end else if (acc) begin
      unique case (st)
        SEL: begin
          if (in_data[31:3] == '0) begin
            st_n        = STREAM;
            bank_n      = {2'b10, in_data[2:0]};
            last_bank_n = {2'b10, in_data[2:0]};
            last_idx_n  = C_LAST;
            cnt_n       = '0;
          end else begin
            st_n    = IDLE;
            err_inc = 2'd1;
          end
        end
        STREAM: begin
          wren_n = 24'd1 << bank;
          addr_n = cnt;
          data_n = in_data;
          if (cnt == last_idx) begin
            cnt_n = '0;
            if (bank == last_bank) begin
              st_n   = DONE;
              done_n = 1'b1;
            end else begin
              bank_n = bank + 5'd1;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
    err_sum = {1'b0, err_count} + {7'd0, err_inc};
    err_n   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge rdclock or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      bank      <= '0;
      last_bank <= '0;
      last_idx  <= '0;
      cnt       <= '0;
      wren      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pack_done <= 1'b0;
      soft_rst  <= 1'b0;
      err_count <= '0;
    end else begin
      st        <= st_n;
      bank      <= bank_n;
      last_bank <= last_bank_n;
      last_idx  <= last_idx_n;
      cnt       <= cnt_n;
      wren      <= wren_n;
      wr_addr   <= addr_n;
      wr_data   <= data_n;
      pack_done <= done_n;
      soft_rst  <= soft_n;
      err_count <= err_n;
    end
  end

endmodule
